// File: rtl/mplier_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
// The optional busy timeout is enabled by defining MPLIER_ARB_TIMEOUT_EN.
package mplier_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StBusy,
        StResp
    } state_e;

    localparam int unsigned DefaultLatency = 11;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mplier_arbiter_rr_picker.sv
// Combinational round-robin selector: picks the first set request strictly
// after the pointer, wrapping around.
module rr_picker
    import mplier_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IdW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdW-1:0]  idx_o,
    output logic            any_o
);

    logic           found;
    logic [IdW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdW'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/mplier_arbiter.sv
// Round-robin front end sharing one Radix8 multiplier among NREQ requesters.
// Optional busy timeout is compiled in with MPLIER_ARB_TIMEOUT_EN.
module mplier_arbiter
    import mplier_arb_pkg::*;
#(
    parameter int unsigned N             = 32,
    parameter int unsigned NREQ          = 4,
    parameter int unsigned LATENCY       = DefaultLatency,
    parameter int unsigned TIMEOUT_SLACK = 4,
    localparam int unsigned IdW          = id_width(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*N-1:0] req_mcand_i,
    input  logic [NREQ*N-1:0] req_mplier_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [IdW-1:0]    resp_id_o,
    output logic [2*N-1:0]    resp_product_o,
    output logic              resp_err_o,
    output logic              mul_rst_o,
    output logic [N-1:0]      mul_mcand_o,
    output logic [N-1:0]      mul_mplier_o,
    input  logic [2*N-1:0]    mul_product_i,
    input  logic              mul_done_i
);

    localparam int unsigned TimeoutLimit = LATENCY + TIMEOUT_SLACK;
    localparam int unsigned CntW         = $clog2(TimeoutLimit + 1) + 1;

    state_e           state_q, state_d;
    logic [IdW-1:0]   ptr_q, id_q, resp_id_q;
    logic [CntW-1:0]  cnt_q;
    logic [N-1:0]     mcand_q, mplier_q;
    logic [2*N-1:0]   prod_q;

    logic [NREQ-1:0]  gnt;
    logic [IdW-1:0]   gnt_idx;
    logic             any_req;
    logic             grant_hs;
    logic             done_hit;
    logic             timeout_hit;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_req)
    );

    assign grant_hs = (state_q == StIdle) && any_req;
    // A done seen on the first BUSY cycle may be left over from the previous run.
    assign done_hit = (state_q == StBusy) && (cnt_q != '0) && mul_done_i;

`ifdef MPLIER_ARB_TIMEOUT_EN
    logic err_q;

    assign timeout_hit = (state_q == StBusy) && !done_hit && (cnt_q == CntW'(TimeoutLimit));
    assign resp_err_o  = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (done_hit) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StLoad;
            StLoad:  state_d = StBusy;
            StBusy:  if (done_hit || timeout_hit) state_d = StResp;
            StResp:  if (resp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if ((state_q == StIdle) && !rst_i) begin
            req_ready_o = gnt;
        end
        resp_valid_o = (state_q == StResp);
        mul_rst_o    = (state_q == StIdle) || (state_q == StLoad);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= IdW'(NREQ - 1);
            id_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            resp_id_q <= '0;
        end else begin
            if (grant_hs) begin
                mcand_q  <= req_mcand_i[gnt_idx*N +: N];
                mplier_q <= req_mplier_i[gnt_idx*N +: N];
                id_q     <= gnt_idx;
                ptr_q    <= gnt_idx;
            end
            if (state_q == StLoad) begin
                cnt_q <= '0;
            end else if ((state_q == StBusy) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (done_hit) begin
                prod_q    <= mul_product_i;
                resp_id_q <= id_q;
            end else if (timeout_hit) begin
                prod_q    <= '0;
                resp_id_q <= id_q;
            end
        end
    end

    assign resp_id_o      = resp_id_q;
    assign resp_product_o = prod_q;
    assign mul_mcand_o    = mcand_q;
    assign mul_mplier_o   = mplier_q;

endmodule

// File: tb/tb_mplier_arbiter.sv
// Scoreboard bench for mplier_arbiter with a behavioural multiplier and
// a round-robin reference model.
module tb_mplier_arbiter;
    import mplier_arb_pkg::*;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = DefaultLatency;
    localparam int unsigned IdW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_mcand = '0;
    logic [NREQ*N-1:0] req_mplier = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [IdW-1:0]    resp_id;
    logic [2*N-1:0]    resp_product;
    logic              resp_err;
    logic              mul_rst;
    logic [N-1:0]      mul_mcand, mul_mplier;
    logic [2*N-1:0]    mul_product;
    logic              mul_done;

    always #5 clk = ~clk;

    mplier_arbiter #(
        .N             (N),
        .NREQ          (NREQ),
        .LATENCY       (LAT),
        .TIMEOUT_SLACK (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_mcand_i    (req_mcand),
        .req_mplier_i   (req_mplier),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_id_o      (resp_id),
        .resp_product_o (resp_product),
        .resp_err_o     (resp_err),
        .mul_rst_o      (mul_rst),
        .mul_mcand_o    (mul_mcand),
        .mul_mplier_o   (mul_mplier),
        .mul_product_i  (mul_product),
        .mul_done_i     (mul_done)
    );

    // Behavioural multiplier: loads while rst is high, done LAT-1 cycles after release.
    logic [N-1:0] m_a = '0, m_b = '0;
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    bit           done_off = 1'b0;

    always @(posedge clk) begin
        if (mul_rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_a    <= mul_mcand;
            m_b    <= mul_mplier;
        end else begin
            if (m_cnt < 1000) m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 2 && !done_off) m_done <= 1'b1;
        end
    end
    assign mul_done    = m_done;
    assign mul_product = m_done ? 64'($signed(m_a)) * 64'($signed(m_b)) : 64'h0;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [63:0]    p;
        logic           err;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] opq[NREQ][$];
    int          checks = 0;
    int          passes = 0;
    int          mp = NREQ - 1;
    int          hs_age = 0;
    logic [63:0] last_op = '0;
    int          rr_mode = 0;
    int          hold_cnt = 0;
    int          resp_seen = 0;
    bit          exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        logic [IdW-1:0] c;
        for (int k = 1; k <= NREQ; k++) begin
            c = IdW'((p + k) % NREQ);
            if (v[c]) return int'(c);
        end
        return -1;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        logic [63:0] op;
        for (int i = 0; i < NREQ; i++) begin
            if (opq[i].size() != 0) begin
                op = opq[i][0];
                req_valid[i]          = 1'b1;
                req_mcand[i*N +: N]   = op[63:32];
                req_mplier[i*N +: N]  = op[31:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_mcand[i*N +: N]   = $urandom;
                req_mplier[i*N +: N]  = $urandom;
            end
        end
        case (rr_mode)
            1: resp_ready = 1'($urandom_range(0, 1));
            2: begin
                if (resp_valid && hold_cnt < 20) begin
                    resp_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    resp_ready = 1'b1;
                end
            end
            default: resp_ready = 1'b1;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) begin
            if (hs_age == 1) begin
                check("mul_rst_load", 64'(mul_rst), 64'd1);
                check("mul_mcand", 64'(mul_mcand), 64'(last_op[63:32]));
                check("mul_mplier", 64'(mul_mplier), 64'(last_op[31:0]));
                hs_age = 2;
            end else if (hs_age == 2) begin
                check("mul_rst_busy", 64'(mul_rst), 64'd0);
                hs_age = 0;
            end
            if (req_ready != '0) begin
                int g;
                logic [NREQ-1:0] oh;
                g = pick(req_valid, mp);
                if (g < 0) begin
                    checks++;
                    $display("FAIL grant_without_request: got %b expected 0", req_ready);
                end else begin
                    oh = '0;
                    oh[IdW'(g)] = 1'b1;
                    check("grant", 64'(req_ready), 64'(oh));
                    last_op = opq[g].pop_front();
                    expq.push_back('{id: IdW'(g),
                                     p: exp_err ? 64'h0 : ref_mul(last_op[63:32], last_op[31:0]),
                                     err: exp_err});
                    mp     = g;
                    hs_age = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || pending()) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", expq.size());
        end
        repeat (2) step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_product", resp_product, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mul_rst", 64'(mul_rst), 64'd1);
        check("rst_mul_mcand", 64'(mul_mcand), 64'd0);
        check("rst_mul_mplier", 64'(mul_mplier), 64'd0);
        expq.delete();
        mp     = NREQ - 1;
        hs_age = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    logic           pv = 1'b0, prdy = 1'b0;
    logic [IdW-1:0] pid = '0;
    logic [63:0]    pprod = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv   <= 1'b0;
            prdy <= 1'b0;
        end else begin
            if (pv && !prdy) begin
                check("resp_hold_valid", 64'(resp_valid), 64'd1);
                check("resp_hold_id", 64'(resp_id), 64'(pid));
                check("resp_hold_product", resp_product, pprod);
            end
            if (pv && prdy) check("resp_after_accept", 64'(resp_valid), 64'd0);
            if (resp_valid) begin
                check("req_ready_in_resp", 64'(req_ready), 64'd0);
                check("mul_rst_in_resp", 64'(mul_rst), 64'd0);
            end
            if (resp_valid && resp_ready) begin
                resp_seen <= resp_seen + 1;
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got id %0d product %h expected none",
                             resp_id, resp_product);
                end else begin
                    automatic exp_t e = expq.pop_front();
                    check("resp_id", 64'(resp_id), 64'(e.id));
                    check("resp_product", resp_product, e.p);
                    check("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
            pv    <= resp_valid;
            prdy  <= resp_ready;
            pid   <= resp_id;
            pprod <= resp_product;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen0;
        drive_inputs();
        apply_reset();

        // Single requester, reference operands.
        opq[1].push_back({32'd1234, -32'sd5678});
        drive_inputs();
        drain(100);

        // All requesters valid from reset: strict rotation starting at 0.
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) opq[i].push_back({$urandom, $urandom});
        drive_inputs();
        drain(400);

        // Back-pressure for 20 cycles on the response.
        rr_mode  = 2;
        hold_cnt = 0;
        opq[3].push_back({$urandom, $urandom});
        drive_inputs();
        drain(100);
        rr_mode = 0;

        // Reset in the 5th BUSY cycle; requester stays valid and is re-granted.
        apply_reset();
        begin
            logic [63:0] op;
            op = {$urandom, $urandom};
            opq[2].push_back(op);
            opq[2].push_back(op);
        end
        drive_inputs();
        n = 0;
        while (hs_age != 1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL grant_timeout: got no grant expected grant to 2");
        end
        repeat (5) step();
        apply_reset();
        drive_inputs();
        drain(100);

        // Signed boundary operands.
        opq[0].push_back({32'h8000_0000, 32'hFFFF_FFFF});
        opq[2].push_back({32'h7FFF_FFFF, 32'd2});
        drive_inputs();
        drain(200);

        // Random traffic with random response back-pressure.
        rr_mode = 1;
        for (int k = 0; k < 40; k++) opq[$urandom_range(0, NREQ - 1)].push_back({$urandom, $urandom});
        drive_inputs();
        drain(3000);
        rr_mode = 0;
        drive_inputs();

        // Multiplier never signals done.
        done_off = 1'b1;
`ifdef MPLIER_ARB_TIMEOUT_EN
        exp_err = 1'b1;
`endif
        opq[1].push_back({$urandom, $urandom});
        drive_inputs();
`ifdef MPLIER_ARB_TIMEOUT_EN
        drain(100);
`else
        seen0 = resp_seen;
        repeat (60) step();
        check("no_resp_count", 64'(resp_seen), 64'(seen0));
        check("no_resp_outstanding", 64'(expq.size()), 64'd1);
`endif
        done_off = 1'b0;
        exp_err  = 1'b0;
        apply_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
